// File: rtl/vm_prod_accum.sv
// -----------------------------------------------------------------------------
// vm_prod_accum
//   Accumulate half of the dot-product datapath. Takes a stream of unsigned
//   products from the Vedic multiplier array and sums up to LEN of them per
//   frame. A beat flagged with in_last closes the frame early. The finished sum,
//   the beat count and a sticky carry-out flag are held on the output handshake
//   until the consumer takes them.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort: drop the frame and any held result
//   in_valid   product beat valid
//   in_ready   block can accept a beat (depends only on state)
//   in_prod    unsigned product, PROD_W bits
//   in_last    beat closes the frame (only when the beat is accepted)
//   out_valid  result held and valid
//   out_ready  consumer takes the result
//   out_sum    frame sum modulo 2^ACC_W
//   out_count  number of beats in the frame (1..LEN)
//   out_ovf    the sum carried out of ACC_W at least once in the frame
// -----------------------------------------------------------------------------
module vm_prod_accum #(
   parameter int PROD_W = 8,
   parameter int ACC_W  = 10,
   parameter int LEN    = 4,
   parameter int CNT_W  = $clog2(LEN + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] in_prod,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf
);

   localparam int SUM_W = ACC_W + 1;

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_HOLD = 1'b1
   } state_t;

   state_t             state_q, state_d;

   logic [ACC_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;

   logic [ACC_W-1:0]   sum_q, sum_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               oflag_q, oflag_d;

   logic               st_acc;
   logic               beat;
   logic               close;
   logic               handoff;
   logic [SUM_W-1:0]   nxt;

   // Add one product to the running sum, keeping the carry out of ACC_W in
   // the top bit so overflow can be tracked while the sum itself wraps.
   function automatic logic [SUM_W-1:0] acc_add(input logic [ACC_W-1:0]  a,
                                                input logic [PROD_W-1:0] p);
      return {1'b0, a} + SUM_W'(p);
   endfunction

   assign st_acc  = (state_q == ST_ACC);
   // clear wins over both handshakes: a beat offered alongside it is dropped.
   assign beat    = in_valid & st_acc & ~clear;
   assign close   = beat & ((cnt_q == CNT_W'(LEN - 1)) | in_last);
   assign handoff = (state_q == ST_HOLD) & out_ready & ~clear;
   assign nxt     = acc_add(acc_q, in_prod);

   // ---- FSM: state register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ACC;
      end else begin
         state_q <= state_d;
      end
   end

   // ---- FSM: next-state logic ----
   always_comb begin
      state_d = state_q;
      if (clear) begin
         state_d = ST_ACC;
      end else begin
         unique case (state_q)
            ST_ACC:  if (close)     state_d = ST_HOLD;
            ST_HOLD: if (out_ready) state_d = ST_ACC;
            default: state_d = ST_ACC;
         endcase
      end
   end

   // ---- FSM: outputs (registered state only, no path from out_ready) ----
   always_comb begin
      in_ready  = (state_q == ST_ACC);
      out_valid = (state_q == ST_HOLD);
   end

   // ---- Accumulate and result capture ----
   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      sum_d   = sum_q;
      count_d = count_q;
      oflag_d = oflag_q;
      if (clear || handoff) begin
         // Result registers are left alone: they are don't-care while
         // out_valid is low and are reloaded at the next frame close.
         acc_d = '0;
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (beat) begin
         acc_d = nxt[ACC_W-1:0];
         ovf_d = ovf_q | nxt[ACC_W];
         cnt_d = cnt_q + CNT_W'(1);
         if (close) begin
            sum_d   = acc_d;
            count_d = cnt_d;
            oflag_d = ovf_d;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         sum_q   <= '0;
         count_q <= '0;
         oflag_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         sum_q   <= sum_d;
         count_q <= count_d;
         oflag_q <= oflag_d;
      end
   end

   assign out_sum   = sum_q;
   assign out_count = count_q;
   assign out_ovf   = oflag_q;

endmodule
